// File: rtl/seg7_scan_decoder.sv
// Display bus monitor: samples a multiplexed 7-segment bus and
// rebuilds the hex value shown on each digit position.
//
// Ports:
//   clk          system clock
//   rst          synchronous active-high reset
//   seg_in       segment lines {A,B,C,D,E,F,G}, 1 = lit
//   dig_sel      one-hot digit enables, bit i selects digit i
//   digits_out   decoded nibbles, digit i at [4i+3:4i]
//   digit_valid  digit i holds a decoded hex value
//   pattern_err  one-cycle pulse when an illegal pattern is captured
//   err_digit    index of the most recent illegal capture
//   frame_done   one-cycle pulse once every digit has been captured
module seg7_scan_decoder #(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [6:0]              seg_in,
  input  logic [NUM_DIGITS-1:0]   dig_sel,
  output logic [4*NUM_DIGITS-1:0] digits_out,
  output logic [NUM_DIGITS-1:0]   digit_valid,
  output logic                    pattern_err,
  output logic [2:0]              err_digit,
  output logic                    frame_done
);

  localparam logic [3:0] CNT_MAX  = 4'(STABLE_CYCLES);
  localparam logic [3:0] CNT_LAST = 4'(STABLE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    CAPTURE,
    HOLD
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [6:0]            s_seg;
  logic [NUM_DIGITS-1:0] s_sel;
  logic [3:0]            cnt;
  logic [NUM_DIGITS-1:0] seen;
  logic [NUM_DIGITS-1:0] seen_nxt;

  logic sel_1h;
  logic in_1h;
  logic same;
  logic stay;
  logic cap;

  logic       dec_ok;
  logic       is_blank;
  logic [3:0] dec_val;

  // Input sampling stage
  always_ff @(posedge clk) begin
    if (rst) begin
      s_seg <= '0;
      s_sel <= '0;
    end else begin
      s_seg <= seg_in;
      s_sel <= dig_sel;
    end
  end

  assign sel_1h = $onehot(s_sel);
  assign in_1h  = $onehot(dig_sel);
  assign same   = (seg_in == s_seg) && (dig_sel == s_sel);
  assign stay   = sel_1h && same;

  // Dwell counter: counts consecutive unchanged one-hot samples
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (stay) begin
      if (cnt != CNT_MAX) begin
        cnt <= cnt + 4'd1;
      end
    end else begin
      cnt <= '0;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (sel_1h) begin
          state_nxt = SETTLE;
        end
      end
      SETTLE: begin
        if (stay && (cnt == CNT_LAST)) begin
          state_nxt = CAPTURE;
        end else if (!in_1h) begin
          state_nxt = IDLE;
        end
      end
      CAPTURE, HOLD: begin
        // A change seen while leaving CAPTURE must not be lost,
        // so CAPTURE reacts to it exactly like HOLD.
        if (!same) begin
          state_nxt = in_1h ? SETTLE : IDLE;
        end else begin
          state_nxt = HOLD;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Output-enable logic: the capture is committed on the edge
  // that enters CAPTURE, so results are visible during it.
  always_comb begin
    cap      = (state == SETTLE) && (state_nxt == CAPTURE);
    seen_nxt = seen | s_sel;
  end

  // Hex font decoder
  always_comb begin
    dec_ok   = 1'b1;
    is_blank = 1'b0;
    dec_val  = 4'h0;
    unique case (s_seg)
      7'h7E: dec_val = 4'h0;
      7'h30: dec_val = 4'h1;
      7'h6D: dec_val = 4'h2;
      7'h79: dec_val = 4'h3;
      7'h33: dec_val = 4'h4;
      7'h5B: dec_val = 4'h5;
      7'h5F: dec_val = 4'h6;
      7'h70: dec_val = 4'h7;
      7'h7F: dec_val = 4'h8;
      7'h73: dec_val = 4'h9;
      7'h77: dec_val = 4'hA;
      7'h1F: dec_val = 4'hB;
      7'h4E: dec_val = 4'hC;
      7'h3D: dec_val = 4'hD;
      7'h4F: dec_val = 4'hE;
      7'h47: dec_val = 4'hF;
      7'h00: begin
        dec_ok   = 1'b0;
        is_blank = 1'b1;
      end
      default: dec_ok = 1'b0;
    endcase
  end

  // Capture results and frame tracking
  always_ff @(posedge clk) begin
    if (rst) begin
      digits_out  <= '0;
      digit_valid <= '0;
      pattern_err <= 1'b0;
      err_digit   <= '0;
      frame_done  <= 1'b0;
      seen        <= '0;
    end else begin
      pattern_err <= 1'b0;
      frame_done  <= 1'b0;
      if (cap) begin
        for (int i = 0; i < NUM_DIGITS; i++) begin
          if (s_sel[i]) begin
            if (dec_ok) begin
              digits_out[4*i +: 4] <= dec_val;
              digit_valid[i]       <= 1'b1;
            end else if (is_blank) begin
              digits_out[4*i +: 4] <= 4'h0;
              digit_valid[i]       <= 1'b0;
            end else begin
              digit_valid[i] <= 1'b0;
              pattern_err    <= 1'b1;
              err_digit      <= 3'(i);
            end
          end
        end
        if (&seen_nxt) begin
          frame_done <= 1'b1;
          seen       <= '0;
        end else begin
          seen <= seen_nxt;
        end
      end
    end
  end

endmodule
